// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 16-word block and streams W0..W63, one per cycle,
// expanding in place inside a 16-entry circular buffer.
module sha256_msg_sched #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [WORD_W-1:0] M_i,
   output logic              w_valid_o,
   output logic [WORD_W-1:0] W_o,
   output logic [5:0]        t_o,
   output logic              sob_o,
   output logic              eob_o,
   output logic              busy_o,
   output logic              ovf_o
);

   typedef enum logic [1:0] {
      LOAD   = 2'b01,
      EXPAND = 2'b10
   } state_t;

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
      sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
      sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   state_t            state;
   state_t            state_next;
   logic [WORD_W-1:0] wbuf [16];
   logic [3:0]        load_cnt;
   logic [5:0]        t_cnt;
   logic [3:0]        idx_t;
   logic [3:0]        idx_m2;
   logic [3:0]        idx_m7;
   logic [3:0]        idx_m15;
   logic [WORD_W-1:0] w_new;

   // Expansion word for round t_cnt; indices wrap naturally in 4 bits.
   always_comb begin
      idx_t   = t_cnt[3:0];
      idx_m2  = t_cnt[3:0] - 4'd2;
      idx_m7  = t_cnt[3:0] - 4'd7;
      idx_m15 = t_cnt[3:0] - 4'd15;
      w_new   = sigma1(wbuf[idx_m2]) + wbuf[idx_m7] + sigma0(wbuf[idx_m15]) + wbuf[idx_t];
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (valid_i && (load_cnt == 4'd15)) begin
               state_next = EXPAND;
            end else begin
               state_next = LOAD;
            end
         end
         EXPAND: begin
            if (t_cnt == LAST_T) begin
               state_next = LOAD;
            end else begin
               state_next = EXPAND;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Buffer, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            wbuf[i] <= '0;
         end
         load_cnt  <= 4'd0;
         t_cnt     <= 6'd0;
         w_valid_o <= 1'b0;
         W_o       <= '0;
         t_o       <= 6'd0;
         sob_o     <= 1'b0;
         eob_o     <= 1'b0;
         busy_o    <= 1'b0;
         ovf_o     <= 1'b0;
      end else begin
         w_valid_o <= 1'b0;
         sob_o     <= 1'b0;
         eob_o     <= 1'b0;
         busy_o    <= (state == EXPAND) || (load_cnt != 4'd0);
         case (state)
            LOAD: begin
               if (valid_i) begin
                  wbuf[load_cnt] <= M_i;
                  W_o            <= M_i;
                  t_o            <= {2'b00, load_cnt};
                  w_valid_o      <= 1'b1;
                  sob_o          <= (load_cnt == 4'd0);
                  if (load_cnt == 4'd15) begin
                     load_cnt <= 4'd0;
                     t_cnt    <= 6'd16;
                  end else begin
                     load_cnt <= load_cnt + 4'd1;
                  end
               end
            end
            EXPAND: begin
               // Words arriving now have nowhere to go; only flag them.
               if (valid_i) begin
                  ovf_o <= 1'b1;
               end
               wbuf[idx_t] <= w_new;
               W_o         <= w_new;
               t_o         <= t_cnt;
               w_valid_o   <= 1'b1;
               eob_o       <= (t_cnt == LAST_T);
               if (t_cnt == LAST_T) begin
                  t_cnt <= 6'd0;
               end else begin
                  t_cnt <= t_cnt + 6'd1;
               end
            end
            default: begin
               load_cnt <= 4'd0;
               t_cnt    <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message schedule stage. Sits directly downstream of the padding preprocessor and upstream of the compression core.
- Accepts the 16 big-endian 32-bit words of one padded 512-bit block and emits W0..W63, one word per cycle, to the compression core.
- Uses a 16-entry circular word buffer for in-place expansion. No block-sized storage beyond that buffer.

Parameters:
- WORD_W, 32, schedule word width. Fixed by SHA-256; other values unsupported.
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  M_i carries a block word this cycle. Driven by the preprocessor valid_o.
- M_i  input  32  block word, word 0 first, bytes big-endian.
- w_valid_o  output  1  W_o/t_o valid this cycle.
- W_o  output  32  schedule word W[t].
- t_o  output  6  round index of W_o, 0..63.
- sob_o  output  1  high with t_o==0.
- eob_o  output  1  high with t_o==63.
- busy_o  output  1  block in progress (LOAD with ≥1 word taken, or EXPAND).
- ovf_o  output  1  sticky; valid_i seen during EXPAND. Cleared only by rst.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst sampled high at posedge), from the following cycle:
  - All outputs 0.
  - Buffer words 0, load_cnt 0, t_cnt 0, state LOAD.
  - Reset mid-block aborts the block; no further W_o words for it.
- States: LOAD, EXPAND. No other states; any illegal encoding → LOAD.
- LOAD:
  - Each cycle valid_i=1: buf[load_cnt] <= M_i.
  - Output registered, next cycle: W_o=M_i, t_o=load_cnt, w_valid_o=1.
  - load_cnt increments.
  - Gaps (valid_i=0) allowed: load_cnt holds, w_valid_o=0 next cycle.
  - On accepting the word with load_cnt==15: load_cnt <= 0, t_cnt <= 16, go to EXPAND.
- EXPAND:
  - Each cycle: W = σ1(buf[(t-2)%16]) + buf[(t-7)%16] + σ0(buf[(t-15)%16]) + buf[t%16], sum mod 2^32, carries discarded.
  - buf[t%16] <= W. Registered outputs W_o=W, t_o=t, w_valid_o=1. t_cnt increments.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - After t==63 is computed: go to LOAD, t_cnt <= 0.
  - A new block may begin on the first LOAD cycle.
- Latency and throughput:
  - One cycle from word acceptance to W_o.
  - Contiguous 16-word input yields 64 consecutive w_valid_o cycles, t_o 0..63, no bubble between t=15 and t=16.
  - EXPAND occupies 48 cycles.
- No backpressure exists upstream.
  - valid_i=1 during EXPAND: word ignored, buffer untouched, ovf_o <= 1.
  - The expansion stream is never disturbed by such words.
- Flags:
  - sob_o/eob_o are registered alongside W_o.
  - busy_o = (state==EXPAND) | (load_cnt!=0), registered.
  - busy_o drops the cycle after eob_o output.
- Buffer indexing: all %16 via 4-bit wrap of t; no subtraction underflow is exposed.

Test Plan:
- "abc" padded block, 16 contiguous words M0=0x61626380, M1..M14=0, M15=0x00000018:
  - W_o t=0..15 echo inputs.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB.
  - 64 contiguous valid cycles; sob_o at t=0, eob_o at t=63.
- Same block with a 3-cycle valid_i gap after word 7 → same W values; 3 idle output cycles; t_o continuous otherwise.
- Two "abc" blocks back-to-back, second starting on the cycle after eob_o → second block W16/W63 identical to the first, ovf_o=0.
- valid_i pulsed at t=30 of EXPAND with M_i=0xFFFFFFFF → ovf_o=1 sticky; W63 still 0x12B1EDEB; next block loads normally.
- rst asserted after word 20 emitted:
  - Next cycle all outputs 0, state LOAD.
  - Fresh "abc" block afterwards produces correct W63.
- All-ones block (all 16 words 0xFFFFFFFF) → W16 = σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF mod 2^32, compared against the software model for all t, checking carry wrap.
